// File: rtl/fwd_scoreboard_pkg.sv
// fwd_scoreboard_pkg: shared constants for the forwarding scoreboard.
//   Tnew/Tuse constants (T0..T2), downstream slot indices (S_E, S_M, S_W)
//   and the default widths/sizes used by fwd_scoreboard and fwd_slot.
package fwd_scoreboard_pkg;

   localparam int unsigned DW_DEF      = 32;
   localparam int unsigned AW_DEF      = 5;
   localparam int unsigned TW_DEF      = 2;
   localparam int unsigned NUM_STG_DEF = 3;
   localparam int unsigned NUM_RD_DEF  = 4;

   // Tnew / Tuse values
   localparam int unsigned T0 = 0;
   localparam int unsigned T1 = 1;
   localparam int unsigned T2 = 2;

   // Slot index of each downstream stage
   localparam int unsigned S_E = 0;
   localparam int unsigned S_M = 1;
   localparam int unsigned S_W = 2;

endpackage

// File: rtl/fwd_slot.sv
// fwd_slot: one tracked pipeline slot {v, addr, tnew}.
//   clk, reset (async, active-low)
//   load            : 1 = capture in_*, 0 = take a bubble (v = 0)
//   in_v/in_addr/in_tnew : candidate content (issue or previous slot)
//   rd_addr         : all read-port addresses, packed NUM_RD*AW
//   v/addr/tnew     : registered slot state
//   match           : per read port, slot valid and address equal (reg 0 excluded)
//   DEC = 1 decrements the incoming tnew (saturating at 0) on capture.
module fwd_slot
   import fwd_scoreboard_pkg::*;
#(
   parameter int unsigned AW     = AW_DEF,
   parameter int unsigned TW     = TW_DEF,
   parameter int unsigned NUM_RD = NUM_RD_DEF,
   parameter bit          DEC    = 1'b0
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 in_v,
   input  logic [AW-1:0]        in_addr,
   input  logic [TW-1:0]        in_tnew,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic                 v,
   output logic [AW-1:0]        addr,
   output logic [TW-1:0]        tnew,
   output logic [NUM_RD-1:0]    match
);

   logic [TW-1:0] tnew_nxt;

   always_comb begin
      tnew_nxt = in_tnew;
      if (DEC && (in_tnew != TW'(T0)))
         tnew_nxt = in_tnew - TW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v    <= 1'b0;
         addr <= '0;
         tnew <= '0;
      end else begin
         v    <= load & in_v;
         addr <= in_addr;
         tnew <= tnew_nxt;
      end
   end

   always_comb begin
      match = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         match[p] = v && (addr == rd_addr[p*AW +: AW]) && (rd_addr[p*AW +: AW] != '0);
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: in-flight destination tracker, D-stage stall and operand
// forwarding for NUM_RD read ports across NUM_STG downstream slots.
//   clk, reset (async, active-low)
//   iss_en/iss_wr/iss_addr/iss_tnew : instruction advancing D->E
//   stall_ext : external bubble request
//   stg_data  : result candidate per slot (slot 0 = E)
//   rd_addr/rd_stg/rd_tuse/rd_raw : per-port address, stage, Tuse, raw operand
//   rd_fwd    : resolved operand per port
//   rd_hit    : per port one-hot source slot, 0 = raw
//   stall     : freeze PC/D, bubble into E
//   stall_cnt : saturating count of stall cycles
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter int unsigned DW      = DW_DEF,
   parameter int unsigned AW      = AW_DEF,
   parameter int unsigned TW      = TW_DEF,
   parameter int unsigned NUM_STG = NUM_STG_DEF,
   parameter int unsigned NUM_RD  = NUM_RD_DEF
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      iss_en,
   input  logic                      iss_wr,
   input  logic [AW-1:0]             iss_addr,
   input  logic [TW-1:0]             iss_tnew,
   input  logic                      stall_ext,
   input  logic [NUM_STG*DW-1:0]     stg_data,
   input  logic [NUM_RD*AW-1:0]      rd_addr,
   input  logic [NUM_RD*TW-1:0]      rd_stg,
   input  logic [NUM_RD*TW-1:0]      rd_tuse,
   input  logic [NUM_RD*DW-1:0]      rd_raw,
   output logic [NUM_RD*DW-1:0]      rd_fwd,
   output logic [NUM_RD*NUM_STG-1:0] rd_hit,
   output logic                      stall,
   output logic [15:0]               stall_cnt
);

   logic                slot_v     [NUM_STG];
   logic [AW-1:0]       slot_addr  [NUM_STG];
   logic [TW-1:0]       slot_tnew  [NUM_STG];
   logic [NUM_RD-1:0]   slot_match [NUM_STG];
   logic [NUM_RD-1:0]   port_stall;
   logic                issue;

   assign issue = iss_en & ~stall;

   for (genvar k = 0; k < NUM_STG; k++) begin : g_slot
      if (k == 0) begin : g_head
         fwd_slot #(.AW(AW), .TW(TW), .NUM_RD(NUM_RD), .DEC(1'b0)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .load    (issue),
            .in_v    (iss_wr & (iss_addr != '0)),
            .in_addr (iss_addr),
            .in_tnew (iss_tnew),
            .rd_addr (rd_addr),
            .v       (slot_v[k]),
            .addr    (slot_addr[k]),
            .tnew    (slot_tnew[k]),
            .match   (slot_match[k])
         );
      end else begin : g_tail
         fwd_slot #(.AW(AW), .TW(TW), .NUM_RD(NUM_RD), .DEC(1'b1)) u_slot (
            .clk     (clk),
            .reset   (reset),
            .load    (1'b1),
            .in_v    (slot_v[k-1]),
            .in_addr (slot_addr[k-1]),
            .in_tnew (slot_tnew[k-1]),
            .rd_addr (rd_addr),
            .v       (slot_v[k]),
            .addr    (slot_addr[k]),
            .tnew    (slot_tnew[k]),
            .match   (slot_match[k])
         );
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      logic [TW-1:0]      stg_p;
      logic [TW-1:0]      tuse_p;
      logic               taken;
      logic [TW-1:0]      sel_tnew;
      logic [DW-1:0]      fwd_p;
      logic [NUM_STG-1:0] hit_p;
      logic               stall_p;

      assign stg_p  = rd_stg[p*TW +: TW];
      assign tuse_p = rd_tuse[p*TW +: TW];

      // Youngest (lowest index) eligible match owns the port even when it is
      // not ready yet; older ready copies behind it are stale.
      always_comb begin
         taken    = 1'b0;
         sel_tnew = '0;
         fwd_p    = rd_raw[p*DW +: DW];
         hit_p    = '0;
         for (int unsigned k = 0; k < NUM_STG; k++) begin
            if (!taken && slot_match[k][p] && (k >= 32'(stg_p))) begin
               taken    = 1'b1;
               sel_tnew = slot_tnew[k];
               if (slot_tnew[k] == TW'(T0)) begin
                  fwd_p    = stg_data[k*DW +: DW];
                  hit_p[k] = 1'b1;
               end
            end
         end
         stall_p = taken && (stg_p == '0) && (sel_tnew > tuse_p);
      end

      assign rd_fwd[p*DW +: DW]           = fwd_p;
      assign rd_hit[p*NUM_STG +: NUM_STG] = hit_p;
      assign port_stall[p]                = stall_p;
   end

   assign stall = stall_ext | (|port_stall);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 16'd1;
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed cycle table, a mid-stall reset sequence and a
// randomized run checked against an issue-history reference model.
module tb_fwd_scoreboard;
   import fwd_scoreboard_pkg::*;

   localparam int DW = 32, AW = 5, TW = 2, NS = 3, NR = 4;
   localparam logic [31:0] RAW0 = 32'h5050_5050;
   localparam logic [31:0] DE   = 32'hE0E0_E0E0;
   localparam logic [31:0] DM   = 32'h0000_0007;
   localparam logic [31:0] DWB  = 32'hDEAD_BEEF;

   logic             clk = 1'b0;
   logic             reset;
   logic             iss_en, iss_wr, stall_ext;
   logic [AW-1:0]    iss_addr;
   logic [TW-1:0]    iss_tnew;
   logic [NS*DW-1:0] stg_data;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*TW-1:0] rd_stg, rd_tuse;
   logic [NR*DW-1:0] rd_raw, rd_fwd;
   logic [NR*NS-1:0] rd_hit;
   logic             stall;
   logic [15:0]      stall_cnt;

   int checks = 0;
   int errors = 0;

   // Reference: what entered E k cycles ago sits in slot k; its remaining
   // Tnew is its issue Tnew minus its age, floored at 0.
   bit         m_v    [NS];
   logic [4:0] m_addr [NS];
   int         m_tnew [NS];
   int         m_cnt;

   fwd_scoreboard #(.DW(DW), .AW(AW), .TW(TW), .NUM_STG(NS), .NUM_RD(NR)) dut (
      .clk(clk), .reset(reset), .iss_en(iss_en), .iss_wr(iss_wr),
      .iss_addr(iss_addr), .iss_tnew(iss_tnew), .stall_ext(stall_ext),
      .stg_data(stg_data), .rd_addr(rd_addr), .rd_stg(rd_stg),
      .rd_tuse(rd_tuse), .rd_raw(rd_raw), .rd_fwd(rd_fwd), .rd_hit(rd_hit),
      .stall(stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         en, wr;
      logic [4:0] ia;
      logic [1:0] it;
      bit         ext;
      logic [4:0] a;
      logic [1:0] stg, tuse;
      bit         x_stall;
      logic [2:0] x_hit;
      logic [31:0] x_fwd;
      int         x_cnt;
   } vec_t;

   vec_t tab [20];

   task automatic check(input string what, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", what, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NS; k++) begin
         m_v[k] = 1'b0; m_addr[k] = '0; m_tnew[k] = 0;
      end
      m_cnt = 0;
   endtask

   task automatic model_eval(output logic [NR*DW-1:0] fwd, output logic [NR*NS-1:0] hit,
                             output logic st);
      fwd = rd_raw;
      hit = '0;
      st  = stall_ext;
      for (int p = 0; p < NR; p++) begin
         logic [4:0] a;
         int stg, tuse, sel, eff;
         a    = rd_addr[p*AW +: AW];
         stg  = int'(rd_stg[p*TW +: TW]);
         tuse = int'(rd_tuse[p*TW +: TW]);
         sel  = -1;
         for (int k = 0; k < NS; k++)
            if (sel < 0 && m_v[k] && m_addr[k] == a && a != 0 && k >= stg) sel = k;
         if (sel >= 0) begin
            eff = m_tnew[sel] - sel;
            if (eff < 0) eff = 0;
            if (eff == 0) begin
               fwd[p*DW +: DW] = stg_data[sel*DW +: DW];
               hit[p*NS + sel] = 1'b1;
            end
            if (stg == 0 && eff > tuse) st = 1'b1;
         end
      end
   endtask

   // Advance one clock; the model consumes the inputs held across the edge.
   task automatic advance();
      logic [NR*DW-1:0] f;
      logic [NR*NS-1:0] h;
      logic st;
      bit en, wr;
      logic [4:0] ia;
      int it;
      model_eval(f, h, st);
      en = iss_en; wr = iss_wr; ia = iss_addr; it = int'(iss_tnew);
      @(posedge clk);
      for (int k = NS - 1; k > 0; k--) begin
         m_v[k] = m_v[k-1]; m_addr[k] = m_addr[k-1]; m_tnew[k] = m_tnew[k-1];
      end
      m_v[0]    = en && !st && wr && (ia != 0);
      m_addr[0] = ia;
      m_tnew[0] = it;
      if (st && m_cnt < 65535) m_cnt++;
      #1;
   endtask

   task automatic set_port0(input logic [4:0] a, input logic [1:0] stg, input logic [1:0] tuse);
      rd_addr = '0; rd_stg = '0; rd_tuse = '0;
      rd_addr[4:0] = a; rd_stg[1:0] = stg; rd_tuse[1:0] = tuse;
   endtask

   task automatic check_model(input string tag);
      logic [NR*DW-1:0] f;
      logic [NR*NS-1:0] h;
      logic st;
      model_eval(f, h, st);
      check({tag, " fwd"}, rd_fwd, f);
      check({tag, " hit"}, rd_hit, h);
      check({tag, " stall"}, stall, st);
      check({tag, " cnt"}, stall_cnt, m_cnt[15:0]);
   endtask

   initial begin
      // en wr ia it ext | a stg tuse | stall hit fwd cnt
      tab[0]  = '{0,0, 5'd0, 2'd0,0, 5'd5, 2'd0,2'd0, 0,3'b000,RAW0,0};
      tab[1]  = '{1,1, 5'd8, 2'd2,0, 5'd5, 2'd0,2'd0, 0,3'b000,RAW0,0};
      tab[2]  = '{1,0, 5'd0, 2'd0,0, 5'd8, 2'd0,2'd0, 1,3'b000,RAW0,0};
      tab[3]  = '{1,0, 5'd0, 2'd0,0, 5'd8, 2'd0,2'd0, 1,3'b000,RAW0,1};
      tab[4]  = '{1,0, 5'd0, 2'd0,0, 5'd8, 2'd0,2'd0, 0,3'b100,DWB ,2};
      tab[5]  = '{1,1, 5'd3, 2'd1,0, 5'd0, 2'd0,2'd0, 0,3'b000,RAW0,2};
      tab[6]  = '{1,0, 5'd0, 2'd0,0, 5'd0, 2'd0,2'd0, 0,3'b000,RAW0,2};
      tab[7]  = '{0,0, 5'd0, 2'd0,0, 5'd3, 2'd1,2'd0, 0,3'b010,DM  ,2};
      tab[8]  = '{1,1, 5'd4, 2'd1,0, 5'd0, 2'd0,2'd0, 0,3'b000,RAW0,2};
      tab[9]  = '{1,1, 5'd4, 2'd1,0, 5'd0, 2'd0,2'd0, 0,3'b000,RAW0,2};
      tab[10] = '{1,1, 5'd4, 2'd1,0, 5'd4, 2'd0,2'd1, 0,3'b000,RAW0,2};
      tab[11] = '{1,0, 5'd0, 2'd0,0, 5'd4, 2'd0,2'd0, 1,3'b000,RAW0,2};
      tab[12] = '{0,0, 5'd0, 2'd0,0, 5'd4, 2'd0,2'd0, 0,3'b010,DM  ,3};
      tab[13] = '{1,1, 5'd0, 2'd2,0, 5'd0, 2'd0,2'd0, 0,3'b000,RAW0,3};
      tab[14] = '{1,0, 5'd0, 2'd0,0, 5'd0, 2'd0,2'd0, 0,3'b000,RAW0,3};
      tab[15] = '{1,1, 5'd9, 2'd2,0, 5'd0, 2'd0,2'd0, 0,3'b000,RAW0,3};
      tab[16] = '{1,1, 5'd10,2'd0,1, 5'd9, 2'd1,2'd0, 1,3'b000,RAW0,3};
      tab[17] = '{1,1, 5'd10,2'd0,1, 5'd9, 2'd1,2'd0, 1,3'b000,RAW0,4};
      tab[18] = '{1,1, 5'd10,2'd0,1, 5'd9, 2'd1,2'd0, 1,3'b100,DWB ,5};
      tab[19] = '{0,0, 5'd0, 2'd0,0, 5'd9, 2'd1,2'd0, 0,3'b000,RAW0,6};

      reset = 1'b0;
      iss_en = 0; iss_wr = 0; iss_addr = '0; iss_tnew = '0; stall_ext = 0;
      stg_data = {DWB, DM, DE};
      rd_raw   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, RAW0};
      set_port0(5'd5, 2'd0, 2'd0);
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;

      for (int i = 0; i < 20; i++) begin
         iss_en = tab[i].en; iss_wr = tab[i].wr; iss_addr = tab[i].ia;
         iss_tnew = tab[i].it; stall_ext = tab[i].ext;
         set_port0(tab[i].a, tab[i].stg, tab[i].tuse);
         #1;
         check($sformatf("tab%0d stall", i), stall, tab[i].x_stall);
         check($sformatf("tab%0d hit0", i), rd_hit[2:0], tab[i].x_hit);
         check($sformatf("tab%0d fwd0", i), rd_fwd[31:0], tab[i].x_fwd);
         check($sformatf("tab%0d cnt", i), stall_cnt, tab[i].x_cnt[15:0]);
         check($sformatf("tab%0d hi_raw", i), rd_fwd[127:32], rd_raw[127:32]);
         advance();
      end

      // Mid-stall asynchronous reset
      iss_en = 1; iss_wr = 1; iss_addr = 5'd6; iss_tnew = 2'd0; stall_ext = 0;
      set_port0(5'd0, 2'd0, 2'd0);
      advance();
      iss_addr = 5'd7; iss_tnew = 2'd1; stall_ext = 1;
      set_port0(5'd6, 2'd0, 2'd0);
      #1 check_model("rst_pre1");
      advance();
      #1 check_model("rst_pre2");
      advance();
      #1 check_model("rst_pre3");
      reset = 1'b0;
      stall_ext = 0;
      #1;
      check("rst cnt", stall_cnt, 16'd0);
      check("rst hit", rd_hit, '0);
      check("rst fwd", rd_fwd, rd_raw);
      check("rst stall", stall, 1'b0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;

      for (int c = 0; c < 3000; c++) begin
         iss_en    = ($urandom_range(0, 3) != 0);
         iss_wr    = $urandom_range(0, 1);
         iss_addr  = 5'($urandom_range(0, 3));
         iss_tnew  = 2'($urandom_range(0, 3));
         stall_ext = ($urandom_range(0, 7) == 0);
         for (int p = 0; p < NR; p++) begin
            rd_addr[p*AW +: AW] = 5'($urandom_range(0, 3));
            rd_stg[p*TW +: TW]  = 2'($urandom_range(0, 3));
            rd_tuse[p*TW +: TW] = 2'($urandom_range(0, 3));
            rd_raw[p*DW +: DW]  = $urandom;
         end
         for (int k = 0; k < NS; k++) stg_data[k*DW +: DW] = $urandom;
         #1;
         check_model($sformatf("rnd%0d", c));
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
